packet_rr_arbiter: RTL and testbench
====================================

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 40, AXIS payload width carried in axis_mosi_t.
REQ-002 SHALL have parameter INPUT_NUMBER, default 5, number of requesting input ports sharing one output channel.
REQ-003 SHALL have parameter INPUT_NUMBER_WIDTH, default $clog2(INPUT_NUMBER), width of the grant index.
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, width of the packet counter.
REQ-005 SHALL have port clk_i, input, 1, clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_mosi_i, input, axis_mosi_t [INPUT_NUMBER], requester streams (TVALID, data.TID, TLAST, payload).
REQ-008 SHALL have port in_miso_o, output, axis_miso_t [INPUT_NUMBER], per-requester TREADY.
REQ-009 SHALL have port out_mosi_o, output, axis_mosi_t, shared output stream.
REQ-010 SHALL have port out_miso_i, input, axis_miso_t, downstream TREADY.
REQ-011 SHALL have port grant_o, output, INPUT_NUMBER_WIDTH, index of the current owner.
REQ-012 SHALL have port grant_valid_o, output, 1, high while in LOCKED.
REQ-013 SHALL have port pkt_count_o, output, COUNT_WIDTH, number of completed packets forwarded.

Function
REQ-014 SHALL implement FSM with states IDLE and LOCKED.
REQ-015 In IDLE, SHALL drive out_mosi_o to all-zero and every in_miso_o TREADY to 0.
REQ-016 In IDLE, with any in_mosi_i[i].TVALID=1, SHALL select the first requester found by searching cyclically from last_grant+1 (mod INPUT_NUMBER), register it into grant, and enter LOCKED the next cycle.
REQ-017 Requester eligibility SHALL depend only on TVALID; TID is not checked at arbitration.
REQ-018 In LOCKED, SHALL connect out_mosi_o = in_mosi_i[grant] and in_miso_o[grant] = out_miso_i; all other in_miso_o TREADY = 0 (combinational path, zero-latency).
REQ-019 In LOCKED, a beat SHALL transfer when out_mosi_o.TVALID && out_miso_i.TREADY.
REQ-020 A transfer with TLAST=1 SHALL return FSM to IDLE next cycle, set last_grant = grant, and increment pkt_count_o by 1.
REQ-021 pkt_count_o SHALL wrap from all-ones to 0 without saturation.
REQ-022 Arbitration latency: first output beat of a new packet SHALL appear no earlier than one cycle after its TVALID rises while IDLE; one idle bubble SHALL separate consecutive packets.
REQ-023 Ownership SHALL NOT change mid-packet, regardless of TVALID dropping on the owner or other requesters asserting.
REQ-024 Single-beat packet (header with TLAST=1) SHALL be handled as a complete packet per REQ-020.
REQ-025 With INPUT_NUMBER=1 the pointer SHALL always resolve to 0 without error.
REQ-026 grant_o SHALL hold its last value in IDLE; grant_valid_o SHALL be 0 in IDLE.

Reset
REQ-027 On rst_n_i=0, SHALL asynchronously force FSM=IDLE, grant=0, last_grant=INPUT_NUMBER-1 (input 0 wins first), pkt_count_o=0, grant_valid_o=0.
REQ-028 Reset mid-packet SHALL abandon the packet; all TREADY and out TVALID SHALL be 0 during and immediately after reset.

Structure
REQ-029 axis_mosi_t, axis_miso_t and ROUTING_HEADER SHALL come from the shared axis type include/package; no local typedefs.
REQ-030 The cyclic priority search SHALL be a sub-module rr_pointer_select (inputs: request vector, last_grant; outputs: index, found).

Verification
REQ-031 Inputs 1 and 3 valid from reset, 3-beat packets, TREADY=1 -> input 1 owns first (beats out cycles 2-4), bubble, input 3 next; pkt_count_o=2.
REQ-032 All 5 inputs continuously valid, 1-beat packets -> grant sequence 0,1,2,3,4,0; one packet every 2 cycles.
REQ-033 Owner 2 drops TVALID mid-packet while input 0 asserts -> grant stays 2 until TLAST transfers; input 0 TREADY=0 throughout.
REQ-034 out TREADY=0 during TLAST beat for 3 cycles -> FSM stays LOCKED, out_mosi_o stable, release only on cycle TREADY=1.
REQ-035 rst_n_i pulsed low mid-packet with pkt_count_o=0xFFFF preset via 65535 packets -> counter wraps to 0 at 65536th; after reset counter 0, IDLE, input 0 wins.

Source files
------------

// File: rtl/packet_rr_arbiter_pkg.sv
// Shared AXI-Stream types and arbiter state encoding for the packet round-robin arbiter.
package packet_rr_arbiter_pkg;

  localparam int AXIS_TID_WIDTH     = 8;
  localparam int AXIS_PAYLOAD_WIDTH = 32;

  // Routing header carried in the data field: destination/source tag plus payload.
  typedef struct packed {
    logic [AXIS_TID_WIDTH-1:0]     TID;
    logic [AXIS_PAYLOAD_WIDTH-1:0] payload;
  } ROUTING_HEADER;

  // Master-to-slave stream signals.
  typedef struct packed {
    logic          TVALID;
    logic          TLAST;
    ROUTING_HEADER data;
  } axis_mosi_t;

  // Slave-to-master stream signals.
  typedef struct packed {
    logic TREADY;
  } axis_miso_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/packet_rr_arbiter_rr_pointer_select.sv
// Cyclic priority search: returns the first set request bit found when
// scanning upward from last_grant+1, wrapping modulo N.
module rr_pointer_select #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_grant_i,
  output logic [W-1:0] index_o,
  output logic         found_o
);

  // Scan N candidates starting just after the previous owner; first hit wins.
  always_comb begin
    int cand;
    cand    = 0;
    index_o = '0;
    found_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant_i) + k) % N;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        index_o = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-level round-robin arbiter: picks one requester while idle and then
// passes its stream through to the shared output until its TLAST beat transfers.
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH    = 40,
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  axis_mosi_t                    in_mosi_i [INPUT_NUMBER],
  output axis_miso_t                    in_miso_o [INPUT_NUMBER],
  output axis_mosi_t                    out_mosi_o,
  input  axis_miso_t                    out_miso_i,
  output logic [INPUT_NUMBER_WIDTH-1:0] grant_o,
  output logic                          grant_valid_o,
  output logic [COUNT_WIDTH-1:0]        pkt_count_o
);

  // Input 0 must win the first arbitration after reset, so the pointer starts on the last input.
  localparam logic [INPUT_NUMBER_WIDTH-1:0] LAST_GRANT_RST = INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);

  arb_state_e                    state_q, state_d;
  logic [INPUT_NUMBER_WIDTH-1:0] grant_q, grant_d;
  logic [INPUT_NUMBER_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [COUNT_WIDTH-1:0]        count_q, count_d;

  logic [INPUT_NUMBER-1:0]       req_vec;
  logic [INPUT_NUMBER_WIDTH-1:0] sel_index;
  logic                          sel_found;
  logic [AXIS_DATA_WIDTH-1:0]    sel_data;

  // Eligibility is TVALID alone; the routing tag plays no part in arbitration.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      req_vec[i] = in_mosi_i[i].TVALID;
    end
  end

  rr_pointer_select #(
    .N(INPUT_NUMBER),
    .W(INPUT_NUMBER_WIDTH)
  ) u_rr_pointer_select (
    .req_i       (req_vec),
    .last_grant_i(last_grant_q),
    .index_o     (sel_index),
    .found_o     (sel_found)
  );

  // Next-state and the zero-latency pass-through mux; IDLE keeps every handshake quiet.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    sel_data     = '0;
    out_mosi_o   = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      in_miso_o[i] = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_index;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        sel_data           = in_mosi_i[grant_q].data;
        out_mosi_o.TVALID  = in_mosi_i[grant_q].TVALID;
        out_mosi_o.TLAST   = in_mosi_i[grant_q].TLAST;
        out_mosi_o.data    = sel_data;
        in_miso_o[grant_q] = out_miso_i;
        if (in_mosi_i[grant_q].TVALID && out_miso_i.TREADY && in_mosi_i[grant_q].TLAST) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          count_d      = count_q + COUNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ownership and packet counter registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_GRANT_RST;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = (state_q == ST_LOCKED);
  assign pkt_count_o   = count_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Self-checking bench for packet_rr_arbiter: directed scenarios plus a
// randomized phase, all compared every cycle against a packet-level model.
module tb_packet_rr_arbiter;
  import packet_rr_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int GW = $clog2(N);
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  axis_mosi_t    in_mosi [N];
  axis_miso_t    in_miso [N];
  axis_mosi_t    out_mosi;
  axis_miso_t    out_miso;
  logic [GW-1:0] grant;
  logic          grant_valid;
  logic [CW-1:0] pkt_count;

  packet_rr_arbiter #(
    .AXIS_DATA_WIDTH   (40),
    .INPUT_NUMBER      (N),
    .INPUT_NUMBER_WIDTH(GW),
    .COUNT_WIDTH       (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_mosi_i    (in_mosi),
    .in_miso_o    (in_miso),
    .out_mosi_o   (out_mosi),
    .out_miso_i   (out_miso),
    .grant_o      (grant),
    .grant_valid_o(grant_valid),
    .pkt_count_o  (pkt_count)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Source-side stimulus state: each input walks through packets of src_len beats.
  logic        want_valid [N];
  logic        out_ready;
  int          src_len    [N];
  int          src_beat   [N];
  logic [31:0] src_payload[N];
  bit          rand_len;

  // Packet-level model: who owns the channel, who owned it last, packets finished.
  bit            m_locked;
  int            m_owner;
  int            m_last;
  int            m_grant;
  logic [CW-1:0] m_count;

  // Snapshot of DUT outputs taken at the compare point of the latest cycle.
  logic [GW-1:0] obs_grant;
  logic          obs_gv;
  logic [CW-1:0] obs_count;
  logic [N-1:0]  obs_ready;
  axis_mosi_t    obs_out;

  function automatic logic [N-1:0] ready_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = in_miso[i].TREADY;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
    m_grant  = 0;
    m_count  = '0;
  endtask

  task automatic checkOutput();
    axis_mosi_t   exp_out;
    logic [N-1:0] exp_ready;
    exp_out   = m_locked ? in_mosi[m_owner] : '0;
    exp_ready = '0;
    if (m_locked && out_ready) exp_ready[m_owner] = 1'b1;
    obs_grant = grant;
    obs_gv    = grant_valid;
    obs_count = pkt_count;
    obs_ready = ready_vec();
    obs_out   = out_mosi;
    check("grant_valid", 64'(obs_gv), 64'(m_locked));
    check("grant", 64'(obs_grant), 64'(m_grant));
    check("pkt_count", 64'(obs_count), 64'(m_count));
    check("out_mosi", 64'(obs_out), 64'(exp_out));
    check("in_tready", 64'(obs_ready), 64'(exp_ready));
  endtask

  // One clock cycle: drive sources, compare against the model, then advance the model.
  task automatic applyStimulus();
    bit found;
    int idx;
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      in_mosi[i].TVALID       = want_valid[i];
      in_mosi[i].TLAST        = (src_beat[i] == src_len[i] - 1);
      in_mosi[i].data.TID     = 8'(i);
      in_mosi[i].data.payload = src_payload[i];
    end
    out_miso.TREADY = out_ready;
    #1;
    checkOutput();
    if (!m_locked) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && want_valid[idx]) begin
          found    = 1'b1;
          m_locked = 1'b1;
          m_owner  = idx;
          m_grant  = idx;
        end
      end
    end else if (want_valid[m_owner] && out_ready) begin
      src_payload[m_owner] = $urandom;
      if (src_beat[m_owner] == src_len[m_owner] - 1) begin
        src_beat[m_owner] = 0;
        if (rand_len) src_len[m_owner] = $urandom_range(1, 4);
        m_locked = 1'b0;
        m_last   = m_owner;
        m_count  = m_count + CW'(1);
      end else begin
        src_beat[m_owner]++;
      end
    end
  endtask

  // Asynchronous reset pulse landing between clock edges, abandoning any packet in flight.
  task automatic pulse_reset();
    #2 rst_n_i = 1'b0;
    #1;
    reset_model();
    check("rst_tready", 64'(ready_vec()), 64'd0);
    check("rst_out_tvalid", 64'(out_mosi.TVALID), 64'd0);
    check("rst_grant_valid", 64'(grant_valid), 64'd0);
    check("rst_count", 64'(pkt_count), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_hold_tready", 64'(ready_vec()), 64'd0);
    check("rst_hold_out_tvalid", 64'(out_mosi.TVALID), 64'd0);
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      in_mosi[i].TVALID = 1'b0;
      want_valid[i]     = 1'b0;
      src_beat[i]       = 0;
    end
    rst_n_i = 1'b1;
    #1;
    check("post_rst_grant_valid", 64'(grant_valid), 64'd0);
    check("post_rst_count", 64'(pkt_count), 64'd0);
    check("post_rst_tready", 64'(ready_vec()), 64'd0);
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n_i         = 1'b1;
    out_miso.TREADY = 1'b0;
    out_ready       = 1'b0;
    rand_len        = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_mosi[i]     = '0;
      want_valid[i]  = 1'b0;
      src_len[i]     = 1;
      src_beat[i]    = 0;
      src_payload[i] = $urandom;
    end
    reset_model();
    #1 rst_n_i = 1'b0;
    #1;
    check("init_grant_valid", 64'(grant_valid), 64'd0);
    check("init_grant", 64'(grant), 64'd0);
    check("init_count", 64'(pkt_count), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Inputs 1 and 3 with 3-beat packets: 1 owns first, bubble, then 3.
    $display("[TB] two requesters, 3-beat packets");
    pulse_reset();
    for (int i = 0; i < N; i++) src_len[i] = 3;
    want_valid[1] = 1'b1;
    want_valid[3] = 1'b1;
    out_ready     = 1'b1;
    for (int s = 0; s <= 8; s++) begin
      applyStimulus();
      if (s == 1) begin
        check("a_first_grant", 64'(obs_grant), 64'd1);
        check("a_first_tid", 64'(obs_out.data.TID), 64'd1);
      end
      if (s == 4) check("a_bubble", 64'(obs_gv), 64'd0);
      if (s == 5) check("a_second_grant", 64'(obs_grant), 64'd3);
      if (s == 8) check("a_count", 64'(obs_count), 64'd2);
    end

    // All inputs valid with single-beat packets: strict rotation, one packet per two cycles.
    $display("[TB] all requesters, 1-beat packets");
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      src_len[i]    = 1;
      want_valid[i] = 1'b1;
    end
    for (int s = 0; s < 12; s++) begin
      applyStimulus();
      if (s % 2 == 1) check("b_grant_seq", 64'(obs_grant), 64'(exp_seq[s / 2]));
      check("b_gv_cadence", 64'(obs_gv), 64'(s % 2));
    end

    // Owner 2 drops TVALID mid-packet while input 0 requests: ownership holds.
    $display("[TB] owner drops valid mid-packet");
    pulse_reset();
    src_len[2]    = 4;
    want_valid[2] = 1'b1;
    for (int s = 0; s <= 8; s++) begin
      want_valid[2] = !(s == 2 || s == 3);
      want_valid[0] = (s >= 2);
      applyStimulus();
      if (s >= 2 && s <= 6) begin
        check("c_hold_grant", 64'(obs_grant), 64'd2);
        check("c_other_tready", 64'(obs_ready[0]), 64'd0);
      end
      if (s == 8) check("c_next_grant", 64'(obs_grant), 64'd0);
    end

    // Downstream stalls the TLAST beat for three cycles.
    $display("[TB] stalled last beat");
    pulse_reset();
    for (int i = 0; i < N; i++) src_len[i] = 1;
    for (int s = 0; s <= 5; s++) begin
      want_valid[4] = (s < 5);
      out_ready     = (s >= 4);
      applyStimulus();
      if (s >= 1 && s <= 3) begin
        check("d_stall_locked", 64'(obs_gv), 64'd1);
        check("d_stall_tlast", 64'(obs_out.TLAST), 64'd1);
        check("d_stall_payload", 64'(obs_out.data.payload), 64'(src_payload[4]));
      end
      if (s == 5) begin
        check("d_release", 64'(obs_gv), 64'd0);
        check("d_count", 64'(obs_count), 64'd1);
      end
    end

    // Counter wrap through all-ones, then reset in the middle of a packet.
    $display("[TB] counter wrap and mid-packet reset");
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) want_valid[i] = 1'b1;
    for (int s = 0; s <= 512; s++) begin
      applyStimulus();
      if (s == 510) check("e_count_max", 64'(obs_count), 64'hFF);
      if (s == 512) check("e_count_wrap", 64'(obs_count), 64'd0);
    end
    for (int i = 0; i < N; i++) src_len[i] = 3;
    applyStimulus();
    applyStimulus();
    pulse_reset();
    for (int i = 0; i < N; i++) want_valid[i] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      applyStimulus();
      if (s == 1) check("e_post_reset_winner", 64'(obs_grant), 64'd0);
    end

    // Randomized traffic with varying lengths, backpressure and occasional resets.
    $display("[TB] randomized traffic");
    pulse_reset();
    rand_len = 1'b1;
    for (int i = 0; i < N; i++) src_len[i] = $urandom_range(1, 4);
    for (int s = 0; s < 3000; s++) begin
      for (int i = 0; i < N; i++) want_valid[i] = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      applyStimulus();
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
